// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage that follows the ALU. It takes one access
// at a time and drives a single-beat valid/ready data-memory port. Loads return
// aligned, sign- or zero-extended data. Misaligned or illegal accesses, and
// requests that time out, complete with an error flag instead of issuing a bus cycle.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 request pulse, sampled only in IDLE
//   is_load, is_store     access direction; exactly one must be set
//   funct3                width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, store_data      effective address and rs2 value
//   busy, done            busy while not IDLE; done pulses for one cycle
//   load_data             extended load result, held until the next completed load
//   err_misalign          with done: misaligned or illegal access
//   err_bus               with done: memory did not respond within TIMEOUT cycles
//   mem_req/we/addr/wstrb/wdata   request side of the memory port
//   mem_ready, mem_rdata  response side of the memory port
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err_misalign,
    output logic        err_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic             r_is_load;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_n;
    logic [2:0]       w_f3_n;
    logic [1:0]       w_off_n;
    logic             w_is_load_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_done_n, w_err_mis_n, w_err_bus_n;
    logic             w_req_n, w_we_n;
    logic [31:0]      w_addr_n, w_wdata_n, w_ld_n;
    logic [3:0]       w_wstrb_n;

    logic             w_bad;
    logic [3:0]       w_st_strb;
    logic [31:0]      w_st_data;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_rd_ext;

    // Request decode: legality/alignment and store lane placement.
    always_comb begin
        w_bad = 1'b0;
        case (funct3)
            3'b000:         w_bad = 1'b0;
            3'b001:         w_bad = addr[0];
            3'b010:         w_bad = |addr[1:0];
            3'b100:         w_bad = is_store;
            3'b101:         w_bad = is_store | addr[0];
            default:        w_bad = 1'b1;
        endcase
        case (funct3[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << addr[1:0];
                w_st_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_st_strb = 4'b0011 << addr[1:0];
                w_st_data = {2{store_data[15:0]}};
            end
            default: begin
                w_st_strb = 4'b1111;
                w_st_data = store_data;
            end
        endcase
    end

    // Load extraction from the returned word using the latched offset and width.
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_f3)
            3'b000:  w_rd_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_rd_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_rd_ext = {24'd0, w_byte};
            3'b101:  w_rd_ext = {16'd0, w_half};
            default: w_rd_ext = mem_rdata;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_n   = r_state;
        w_f3_n      = r_f3;
        w_off_n     = r_off;
        w_is_load_n = r_is_load;
        w_cnt_n     = r_cnt;
        w_done_n    = 1'b0;
        w_err_mis_n = 1'b0;
        w_err_bus_n = 1'b0;
        w_req_n     = mem_req;
        w_we_n      = mem_we;
        w_addr_n    = mem_addr;
        w_wstrb_n   = mem_wstrb;
        w_wdata_n   = mem_wdata;
        w_ld_n      = load_data;

        case (r_state)
            S_IDLE: begin
                if (start && (is_load ^ is_store)) begin
                    w_f3_n      = funct3;
                    w_off_n     = addr[1:0];
                    w_is_load_n = is_load;
                    if (w_bad) begin
                        w_state_n   = S_DONE;
                        w_done_n    = 1'b1;
                        w_err_mis_n = 1'b1;
                    end else begin
                        w_state_n = S_REQ;
                        w_cnt_n   = '0;
                        w_req_n   = 1'b1;
                        w_we_n    = is_store;
                        w_addr_n  = {addr[31:2], 2'b00};
                        w_wstrb_n = is_store ? w_st_strb : 4'b0000;
                        w_wdata_n = is_store ? w_st_data : 32'd0;
                    end
                end
            end
            S_REQ: begin
                // Handshake takes priority over a timeout on the same cycle.
                if (mem_ready || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                    w_state_n   = S_DONE;
                    w_done_n    = 1'b1;
                    w_err_bus_n = ~mem_ready;
                    w_req_n     = 1'b0;
                    w_we_n      = 1'b0;
                    w_addr_n    = 32'd0;
                    w_wstrb_n   = 4'b0000;
                    w_wdata_n   = 32'd0;
                    if (r_is_load) begin
                        w_ld_n = mem_ready ? w_rd_ext : 32'd0;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_f3         <= 3'd0;
            r_off        <= 2'd0;
            r_is_load    <= 1'b0;
            r_cnt        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            load_data    <= 32'd0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wstrb    <= 4'b0000;
            mem_wdata    <= 32'd0;
        end else begin
            r_state      <= w_state_n;
            r_f3         <= w_f3_n;
            r_off        <= w_off_n;
            r_is_load    <= w_is_load_n;
            r_cnt        <= w_cnt_n;
            busy         <= (w_state_n != S_IDLE);
            done         <= w_done_n;
            load_data    <= w_ld_n;
            err_misalign <= w_err_mis_n;
            err_bus      <= w_err_bus_n;
            mem_req      <= w_req_n;
            mem_we       <= w_we_n;
            mem_addr     <= w_addr_n;
            mem_wstrb    <= w_wstrb_n;
            mem_wdata    <= w_wdata_n;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single accesses with
// hand-computed results, plus sequences for timeout, ignored starts and
// reset in the middle of a request.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset, start, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, err_misalign, err_bus;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data),
        .err_misalign(err_misalign), .err_bus(err_bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          waits;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld_exp;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int w, input logic mis,
                                input logic [31:0] ma, input logic [3:0] ws,
                                input logic [31:0] wd, input logic [31:0] le);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rd;
        v.waits = w; v.mis = mis; v.maddr = ma; v.wstrb = ws; v.wdata = wd; v.ld_exp = le;
        return v;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk32(nm, 32'(act), 32'(exp));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk);
        start = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
        addr = v.addr; store_data = v.sd; mem_ready = 1'b0; mem_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = 32'hFFFF_FFFF; store_data = 32'h5555_5555;
        if (v.mis) begin
            chk1({tag, " mis done"}, done, 1'b1);
            chk1({tag, " mis err"}, err_misalign, 1'b1);
            chk1({tag, " mis req"}, mem_req, 1'b0);
            chk32({tag, " mis ld"}, load_data, v.ld_exp);
        end else begin
            for (int k = 0; k <= v.waits; k++) begin
                chk1($sformatf("%s req c%0d", tag, k), mem_req, 1'b1);
                chk1($sformatf("%s busy c%0d", tag, k), busy, 1'b1);
                chk1($sformatf("%s done c%0d", tag, k), done, 1'b0);
                chk32($sformatf("%s addr c%0d", tag, k), mem_addr, v.maddr);
                chk1($sformatf("%s we c%0d", tag, k), mem_we, v.st);
                chk32($sformatf("%s wstrb c%0d", tag, k), 32'(mem_wstrb), 32'(v.wstrb));
                if (v.st) chk32($sformatf("%s wdata c%0d", tag, k), mem_wdata, v.wdata);
                if (k == v.waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
                @(negedge clk);
            end
            mem_ready = 1'b0; mem_rdata = 32'hDEAD_DEAD;
            chk1({tag, " done"}, done, 1'b1);
            chk1({tag, " req off"}, mem_req, 1'b0);
            chk1({tag, " err_bus"}, err_bus, 1'b0);
            chk1({tag, " err_mis"}, err_misalign, 1'b0);
            chk32({tag, " ld"}, load_data, v.ld_exp);
        end
        @(negedge clk);
        chk1({tag, " idle done"}, done, 1'b0);
        chk1({tag, " idle busy"}, busy, 1'b0);
        chk1({tag, " idle err"}, err_misalign | err_bus, 1'b0);
        chk32({tag, " held ld"}, load_data, v.ld_exp);
    endtask

    initial begin
        int cnt;
        vec_t v;
        // ld st f3 addr sd rdata waits mis maddr wstrb wdata ld_exp
        vecs[0]  = mk(1, 0, 3'b000, 32'h0000_1003, 0, 32'h80FF_0000, 0, 0, 32'h0000_1000, 4'b0000, 0, 32'hFFFF_FF80);
        vecs[1]  = mk(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 3, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 0, 3'b010, 32'h0000_3001, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FF80);
        vecs[3]  = mk(0, 1, 3'b100, 32'h0000_3000, 32'h1234_5678, 0, 0, 1, 0, 0, 0, 32'hFFFF_FF80);
        vecs[4]  = mk(1, 0, 3'b010, 32'h0000_5000, 0, 32'h1234_5678, 1, 0, 32'h0000_5000, 4'b0000, 0, 32'h1234_5678);
        vecs[5]  = mk(1, 0, 3'b001, 32'h0000_6002, 0, 32'h8001_7FFF, 0, 0, 32'h0000_6000, 4'b0000, 0, 32'hFFFF_8001);
        vecs[6]  = mk(1, 0, 3'b101, 32'h0000_6000, 0, 32'h8001_F00D, 0, 0, 32'h0000_6000, 4'b0000, 0, 32'h0000_F00D);
        vecs[7]  = mk(1, 0, 3'b100, 32'h0000_7001, 0, 32'h0000_9A00, 2, 0, 32'h0000_7000, 4'b0000, 0, 32'h0000_009A);
        vecs[8]  = mk(0, 1, 3'b000, 32'h0000_8001, 32'h1234_56C3, 0, 0, 0, 32'h0000_8000, 4'b0010, 32'hC3C3_C3C3, 32'h0000_009A);
        vecs[9]  = mk(0, 1, 3'b010, 32'h0000_9000, 32'hDEAD_BEEF, 0, 2, 0, 32'h0000_9000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_009A);
        vecs[10] = mk(0, 1, 3'b001, 32'h0000_9001, 32'h0000_1111, 0, 0, 1, 0, 0, 0, 32'h0000_009A);
        vecs[11] = mk(1, 0, 3'b000, 32'h0000_A000, 0, 32'h0000_007F, 0, 0, 32'h0000_A000, 4'b0000, 0, 32'h0000_007F);
        vecs[12] = mk(1, 0, 3'b011, 32'h0000_0000, 0, 0, 0, 1, 0, 0, 0, 32'h0000_007F);

        reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'd0; store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk32("rst ld", load_data, 32'd0);
        chk1("rst errs", err_misalign | err_bus, 1'b0);
        chk1("rst req", mem_req, 1'b0);
        chk1("rst we", mem_we, 1'b0);
        chk32("rst addr", mem_addr, 32'd0);
        chk32("rst wstrb", 32'(mem_wstrb), 32'd0);
        chk32("rst wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // LHU with no memory response: 16 request cycles, then bus error.
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; funct3 = 3'b101; addr = 32'h0000_4002;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0;
        cnt = 0;
        while (mem_req && cnt < 40) begin
            chk32("to addr", mem_addr, 32'h0000_4000);
            cnt++;
            @(negedge clk);
        end
        chk32("to req cycles", 32'(cnt), 32'd16);
        chk1("to done", done, 1'b1);
        chk1("to err_bus", err_bus, 1'b1);
        chk1("to err_mis", err_misalign, 1'b0);
        chk32("to ld", load_data, 32'd0);
        @(negedge clk);
        chk1("to idle err", err_bus, 1'b0);
        chk1("to idle done", done, 1'b0);

        // Start while a request is outstanding, and an ambiguous direction in IDLE.
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h0000_B000;
        @(negedge clk);
        chk1("ign req1", mem_req, 1'b1);
        start = 1'b1; is_load = 1'b0; is_store = 1'b1; addr = 32'h0000_B100; store_data = 32'h1111_1111;
        @(negedge clk);
        chk1("ign req2", mem_req, 1'b1);
        chk32("ign addr", mem_addr, 32'h0000_B000);
        chk1("ign we", mem_we, 1'b0);
        start = 1'b0; is_store = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'hDEAD_DEAD;
        chk1("ign done", done, 1'b1);
        chk32("ign ld", load_data, 32'hCAFE_F00D);
        start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_B200;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_req || done || busy) cnt++;
        end
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        chk32("ign extra activity", 32'(cnt), 32'd0);

        // Reset in the second request cycle abandons the access.
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h0000_C000;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0;
        chk1("mrst req1", mem_req, 1'b1);
        @(negedge clk);
        chk1("mrst req2", mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("mrst req", mem_req, 1'b0);
        chk1("mrst busy", busy, 1'b0);
        chk1("mrst done", done, 1'b0);
        @(negedge clk);
        chk1("mrst no done", done, 1'b0);
        chk1("mrst no req", mem_req, 1'b0);
        v = mk(1, 0, 3'b010, 32'h0000_C004, 0, 32'h0BAD_CAFE, 0, 0, 32'h0000_C004, 4'b0000, 0, 32'h0BAD_CAFE);
        run_vec("post-rst lw", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
